// File: rtl/led_seq_pkg.sv
// Shared definitions for the LED sequencer: register offsets, MODE
// encodings and the sequencer FSM state type.
package led_seq_pkg;

  // Slave register offsets
  localparam logic [1:0] ADDR_CTRL    = 2'd0;
  localparam logic [1:0] ADDR_PATTERN = 2'd1;
  localparam logic [1:0] ADDR_PERIOD  = 2'd2;
  localparam logic [1:0] ADDR_STATUS  = 2'd3;

  // CTRL.MODE encodings
  localparam logic [1:0] MODE_STATIC = 2'b00;
  localparam logic [1:0] MODE_ROL    = 2'b01;
  localparam logic [1:0] MODE_ROR    = 2'b10;
  localparam logic [1:0] MODE_BLINK  = 2'b11;

  // Sequencer FSM states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_COUNT = 2'd2
  } state_t;

endpackage

// File: rtl/led_seq_step.sv
// Next-pattern computation: given the mode, the current LED value and the
// blink phase, produce the value for the next strobe. A pending reload
// overrides the mode step and restarts blink in the "on" phase.
module led_seq_step
  import led_seq_pkg::*;
(
  input  logic [1:0] i_mode,
  input  logic [7:0] i_cur,
  input  logic       i_phase,
  input  logic [7:0] i_pattern,
  input  logic       i_reload,
  output logic [7:0] o_next_cur,
  output logic       o_next_phase
);

  // Select the next LED value and blink phase
  always_comb begin
    o_next_cur   = i_cur;
    o_next_phase = i_phase;
    if (i_reload) begin
      o_next_cur   = i_pattern;
      o_next_phase = 1'b1;
    end else begin
      case (i_mode)
        MODE_ROL:   o_next_cur = {i_cur[6:0], i_cur[7]};
        MODE_ROR:   o_next_cur = {i_cur[0], i_cur[7:1]};
        MODE_BLINK: begin
          // phase=1 means the pattern is currently shown
          o_next_cur   = i_phase ? 8'h00 : i_pattern;
          o_next_phase = ~i_phase;
        end
        default:    o_next_cur = i_cur;
      endcase
    end
  end

endmodule

// File: rtl/led_seq_ctrl.sv
// LED sequencer: a small register file on a config slave port, and an FSM
// that periodically pushes the current LED value out through a PIO master
// write. Strobes repeat every PERIOD+2 cycles while CTRL.EN is set.
//
// Master handshake: the PIO slave is zero-wait; a write is one cycle with
// m_chipselect=1 and m_write_n=0, accepted unconditionally in that cycle.
module led_seq_ctrl
  import led_seq_pkg::*;
#(
  parameter int PERIOD_W = 24
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  address,
  input  logic        chipselect,
  input  logic        write_n,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic [1:0]  m_address,
  output logic        m_chipselect,
  output logic        m_write_n,
  output logic [7:0]  m_writedata,
  output logic [1:0]  dbg_state
);

  logic                r_en;
  logic [1:0]          r_mode;
  logic [7:0]          r_pattern;
  logic [PERIOD_W-1:0] r_period;
  logic [7:0]          r_cur;
  logic [PERIOD_W-1:0] r_count;
  logic                r_reload;
  logic                r_phase;
  state_t              r_state;
  state_t              w_next_state;

  logic       w_wr, w_wr_ctrl, w_wr_pat, w_wr_per;
  logic       w_busy, w_start, w_load_cnt, w_step, w_dec;
  logic [7:0] w_pat_eff;
  logic       w_reload_eff;
  logic [7:0] w_next_cur;
  logic       w_next_phase;
  logic       w_unused_wdata;

  assign w_wr      = chipselect & ~write_n;
  assign w_wr_ctrl = w_wr && (address == ADDR_CTRL);
  assign w_wr_pat  = w_wr && (address == ADDR_PATTERN);
  assign w_wr_per  = w_wr && (address == ADDR_PERIOD);
  assign w_busy    = (r_state != ST_IDLE);
  // Upper writedata bits are don't-care for every register
  assign w_unused_wdata = ^writedata;

  // A PATTERN write landing on the step edge is used directly
  assign w_pat_eff    = w_wr_pat ? writedata[7:0] : r_pattern;
  assign w_reload_eff = r_reload | w_wr_pat;

  // Register file writes
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_en      <= 1'b0;
      r_mode    <= MODE_STATIC;
      r_pattern <= 8'h00;
      r_period  <= '0;
    end else begin
      if (w_wr_ctrl) begin
        r_en   <= writedata[0];
        r_mode <= writedata[2:1];
      end
      if (w_wr_pat) r_pattern <= writedata[7:0];
      if (w_wr_per) r_period  <= writedata[PERIOD_W-1:0];
    end
  end

  // FSM state register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_next_state;
  end

  // FSM next state, datapath controls and master strobe
  always_comb begin
    w_next_state = r_state;
    w_start      = 1'b0;
    w_load_cnt   = 1'b0;
    w_step       = 1'b0;
    w_dec        = 1'b0;
    m_chipselect = 1'b0;
    m_write_n    = 1'b1;
    case (r_state)
      ST_IDLE: begin
        if (r_en) begin
          w_start      = 1'b1;
          w_next_state = ST_WRITE;
        end
      end
      ST_WRITE: begin
        m_chipselect = 1'b1;
        m_write_n    = 1'b0;
        w_load_cnt   = 1'b1;
        w_next_state = r_en ? ST_COUNT : ST_IDLE;
      end
      ST_COUNT: begin
        if (!r_en) begin
          w_next_state = ST_IDLE;
        end else if (r_count == '0) begin
          w_step       = 1'b1;
          w_next_state = ST_WRITE;
        end else begin
          w_dec = 1'b1;
        end
      end
      default: w_next_state = ST_IDLE;
    endcase
  end

  led_seq_step u_step (
    .i_mode       (r_mode),
    .i_cur        (r_cur),
    .i_phase      (r_phase),
    .i_pattern    (w_pat_eff),
    .i_reload     (w_reload_eff),
    .o_next_cur   (w_next_cur),
    .o_next_phase (w_next_phase)
  );

  // Current LED value, blink phase and interval counter
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_cur   <= 8'h00;
      r_phase <= 1'b0;
      r_count <= '0;
    end else begin
      if (w_start) begin
        r_cur   <= r_pattern;
        r_phase <= 1'b1;
      end else if (w_step) begin
        r_cur   <= w_next_cur;
        r_phase <= w_next_phase;
      end
      if (w_load_cnt)  r_count <= r_period;
      else if (w_dec)  r_count <= r_count - 1'b1;
    end
  end

  // Reload flag: set by a PATTERN write while busy, consumed by the next step
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                 r_reload <= 1'b0;
    else if (w_step || w_start)   r_reload <= 1'b0;
    else if (w_wr_pat && w_busy)  r_reload <= 1'b1;
  end

  // Zero-wait register readback
  always_comb begin
    readdata = 32'd0;
    case (address)
      ADDR_CTRL:    readdata = {29'd0, r_mode, r_en};
      ADDR_PATTERN: readdata = {24'd0, r_pattern};
      ADDR_PERIOD:  readdata = 32'(r_period);
      ADDR_STATUS:  readdata = {16'd0, r_cur, 7'd0, w_busy};
      default:      readdata = 32'd0;
    endcase
  end

  assign m_address   = 2'b00;
  assign m_writedata = r_cur;
  assign dbg_state   = r_state;

endmodule

// File: doc/led_seq_ctrl.md
LED_SEQ_CTRL -- requirements
Module: led_seq_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock, all state rising-edge.
REQ-002 SHALL have port reset_n, input, 1 bit: reset, asynchronous and active-low.
REQ-003 SHALL have config slave ports: address in 2 bits, chipselect in 1, write_n in 1, writedata in 32, readdata out 32.
REQ-004 SHALL have PIO master ports: m_address out 2, constant 0; m_chipselect out 1; m_write_n out 1; m_writedata out 8.
REQ-005 SHALL have parameter PERIOD_W, default 24: width of the PERIOD register and of the interval counter.

Function
REQ-006 SHALL decode register map: 0 CTRL (bit0 EN, bits2:1 MODE), 1 PATTERN[7:0], 2 PERIOD[PERIOD_W-1:0], 3 STATUS (read-only).
REQ-007 SHALL accept a slave write when chipselect=1 and write_n=0, taking effect at the next clk edge.
REQ-008 SHALL return readdata combinationally with zero wait states: registers zero-extended; STATUS = {cur[7:0] in bits15:8, busy in bit0}.
REQ-009 SHALL decode MODE as: 00 static, 01 rotate-left, 10 rotate-right, 11 blink (alternate PATTERN and 8'h00).
REQ-010 SHALL implement FSM states IDLE, WRITE and COUNT; busy=1 whenever the state is not IDLE.
REQ-011 SHALL, in IDLE with EN=1, load cur=PATTERN and move to WRITE on the next edge.
REQ-012 SHALL, in WRITE, drive m_chipselect=1, m_write_n=0 and m_writedata=cur for exactly one cycle, then load counter=PERIOD and move to COUNT.
REQ-013 SHALL, in COUNT, decrement the counter each cycle; at counter==0, compute the next cur per MODE and move to WRITE.
REQ-014 SHALL space consecutive master write strobes exactly PERIOD+2 cycles apart; PERIOD=0 yields one strobe every 2 cycles.
REQ-015 SHALL drive m_chipselect=0, m_write_n=1 and m_writedata=cur in every state other than WRITE.
REQ-016 SHALL, when EN is cleared during COUNT, return to IDLE on the next edge with no further strobe.
REQ-017 SHALL, when EN is cleared during WRITE, complete that strobe and then go to IDLE.
REQ-018 SHALL, on a PATTERN write while busy, set a reload flag; the next next-value computation then uses cur=PATTERN (reset blink phase to "on") instead of the MODE step, and clears the flag.
REQ-019 SHALL, when a PATTERN write coincides with the counter==0 step, use the new PATTERN value.
REQ-020 SHALL apply a MODE change while busy at the next step, without reloading cur.
REQ-021 SHALL rotate by 1 bit circularly, with wrap-around (for example 8'h80 rotate-left gives 8'h01).
REQ-022 SHALL let a PERIOD write while busy affect only the next counter load.

Reset
REQ-023 SHALL, on reset_n=0, asynchronously clear CTRL, PATTERN, PERIOD, cur, the counter, the reload flag and the blink phase; state=IDLE.
REQ-024 SHALL hold outputs during reset at m_chipselect=0, m_write_n=1, m_writedata=0, readdata per zeroed registers.
REQ-025 SHALL, when reset is asserted mid-strobe, deassert the strobe immediately, with no partial write retained.

Structure
REQ-026 SHALL place register offsets, MODE encodings and the FSM state enum in shared package led_seq_pkg.
REQ-027 SHALL place the next-pattern computation (MODE, cur, phase -> next cur, next phase) in combinational sub-module led_seq_step.
REQ-028 SHALL keep the FSM, counter and register file in led_seq_ctrl; no other hierarchy.

Verification
REQ-029 SHALL cover: PATTERN=8'h81, PERIOD=3, MODE=01, EN=1 -> strobes carry 81, 03, 06, 0C, spaced 5 cycles, first strobe 2 cycles after the EN write.
REQ-030 SHALL cover: MODE=11, PATTERN=8'hA5, PERIOD=0 -> strobes every 2 cycles alternating A5, 00, A5.
REQ-031 SHALL cover: EN cleared mid-COUNT with PERIOD=10 -> no further strobe, busy=0 one cycle later, m_writedata holds last cur.
REQ-032 SHALL cover: PATTERN=8'h3C written on the exact counter==0 cycle during rotate-right -> next strobe carries 3C, followed by 1E.
REQ-033 SHALL cover: reset_n pulsed during a WRITE cycle -> m_chipselect falls in the same cycle, all readdata=0, no strobe until EN is rewritten.
REQ-034 SHALL cover: STATUS read while running -> bits15:8 equal the last strobed value and bit0=1; MODE=10 with 8'h01 gives 8'h80 (wrap).
